// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sensor filter.
// Holds the FSM state encoding and the default debounce/holdoff lengths.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARMED     = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_TRIGGERED = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_HOLDOFF_CYCLES  = 32;

endpackage

// File: rtl/alarm_sync.sv
// Two-flop synchronizer for the asynchronous sensor line.
// Ports:
//   clk     - sampling clock
//   reset   - asynchronous active-low reset, clears both flops
//   raw_in  - asynchronous input
//   sync_in - synchronized output (second flop)
module alarm_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic sync_in
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= '0;
      sync_in <= '0;
    end else begin
      meta    <= raw_in;
      sync_in <= meta;
    end
  end

endmodule

// File: rtl/alarm_sensor_filter.sv
// Debounces an asynchronous alarm sensor and produces a latched trigger.
// A sensor level must stay high for DEBOUNCE_CYCLES synchronized samples to
// qualify; the trigger holds until acknowledged, then a holdoff period runs
// and re-arming additionally requires the sensor to have cleared.
// Ports:
//   clk         - single clock
//   reset       - asynchronous active-low reset
//   raw_in      - asynchronous sensor line
//   arm         - enable; low forces DISARMED
//   ack         - acknowledge, only honoured while triggered
//   trig        - registered trigger level
//   armed       - registered, high in every state except DISARMED
//   event_count - saturating count of qualified triggers
module alarm_sensor_filter
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEFAULT_HOLDOFF_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  input  logic       arm,
  input  logic       ack,
  output logic       trig,
  output logic       armed,
  output logic [7:0] event_count
);

  localparam logic [7:0] QUAL_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

  logic       sync_in;
  state_t     state, state_next;
  logic [7:0] qcnt, qcnt_next;
  logic [7:0] hcnt, hcnt_next;
  logic       trig_next;
  logic       armed_next;
  logic       count_inc;

  alarm_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .sync_in (sync_in)
  );

  always_comb begin
    state_next = state;
    qcnt_next  = qcnt;
    hcnt_next  = hcnt;
    if (!arm) begin
      state_next = ST_DISARMED;
      qcnt_next  = '0;
      hcnt_next  = '0;
    end else begin
      case (state)
        ST_DISARMED: state_next = ST_ARMED;
        ST_ARMED: begin
          if (sync_in) begin
            state_next = ST_QUALIFY;
            qcnt_next  = 8'd1;
          end
        end
        ST_QUALIFY: begin
          if (!sync_in) begin
            state_next = ST_ARMED;
            qcnt_next  = '0;
          end else if (qcnt == QUAL_LAST) begin
            state_next = ST_TRIGGERED;
            qcnt_next  = '0;
          end else begin
            qcnt_next = qcnt + 8'd1;
          end
        end
        ST_TRIGGERED: begin
          if (ack) begin
            state_next = ST_HOLDOFF;
            hcnt_next  = '0;
          end
        end
        ST_HOLDOFF: begin
          // Counter parks at its last value; leaving also needs a clear sensor.
          if (hcnt == HOLD_LAST) begin
            if (!sync_in) begin
              state_next = ST_ARMED;
              hcnt_next  = '0;
            end
          end else begin
            hcnt_next = hcnt + 8'd1;
          end
        end
        default: begin
          state_next = ST_DISARMED;
          qcnt_next  = '0;
          hcnt_next  = '0;
        end
      endcase
    end

    // Outputs are registered copies of the next-state decode.
    trig_next  = (state_next == ST_TRIGGERED);
    armed_next = (state_next != ST_DISARMED);
    count_inc  = trig_next && (state != ST_TRIGGERED) && (event_count != 8'hFF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_DISARMED;
      qcnt        <= '0;
      hcnt        <= '0;
      trig        <= 1'b0;
      armed       <= 1'b0;
      event_count <= '0;
    end else begin
      state <= state_next;
      qcnt  <= qcnt_next;
      hcnt  <= hcnt_next;
      trig  <= trig_next;
      armed <= armed_next;
      if (count_inc) event_count <= event_count + 8'd1;
    end
  end

endmodule

// File: doc/alarm_sensor_filter.md
ALARM_SENSOR_FILTER -- requirements
Module: alarm_sensor_filter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive synchronized-high samples required to qualify a trigger (legal 2..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 32, cycles trig stays suppressed after acknowledge (legal 1..255).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port raw_in  input  1  asynchronous sensor line.
REQ-006 Port arm  input  1  synchronous enable; low forces disarmed.
REQ-007 Port ack  input  1  synchronous acknowledge; clears an active trigger.
REQ-008 Port trig  output  1  registered level feeding the downstream alarm's "in" input.
REQ-009 Port armed  output  1  registered; high in every state except DISARMED.
REQ-010 Port event_count  output  8  registered count of qualified triggers, saturating.

Function
REQ-011 The block SHALL pass raw_in through a two-flop synchronizer; sync_in is the second flop.
REQ-012 The block SHALL implement FSM states DISARMED, ARMED, QUALIFY, TRIGGERED, HOLDOFF.
REQ-013 DISARMED -> ARMED when arm=1; otherwise stay.
REQ-014 ARMED -> QUALIFY when sync_in=1, loading qcnt=1; otherwise stay.
REQ-015 QUALIFY: sync_in=0 -> ARMED, qcnt cleared; sync_in=1 and qcnt=DEBOUNCE_CYCLES-1 -> TRIGGERED; else qcnt+1.
REQ-016 With raw_in held high from first sampling edge E1, trig SHALL be high after edge E(DEBOUNCE_CYCLES+2) and not before.
REQ-017 TRIGGERED: trig=1; stay until ack=1, then -> HOLDOFF with hcnt=0; sensor level is ignored.
REQ-018 On each entry to TRIGGERED event_count SHALL increment by 1, saturating at 255 (no wrap).
REQ-019 HOLDOFF: trig=0; hcnt increments each cycle until HOLDOFF_CYCLES-1, then holds.
REQ-020 HOLDOFF -> ARMED only when hcnt=HOLDOFF_CYCLES-1 and sync_in=0; with sync_in=1 stay in HOLDOFF (re-arm requires sensor clear).
REQ-021 arm=0 in any state SHALL force DISARMED at the next edge, clearing qcnt, hcnt and trig; this takes priority over ack and sync_in.
REQ-022 ack in any state other than TRIGGERED SHALL be ignored.
REQ-023 ack and arm=0 in the same TRIGGERED cycle SHALL go to DISARMED, not HOLDOFF.
REQ-024 trig SHALL be a flop output equal to (next state == TRIGGERED); no combinational path from inputs to outputs.

Reset
REQ-025 reset=0 SHALL immediately force DISARMED, trig=0, armed=0, event_count=0, qcnt=0, hcnt=0, synchronizer flops=0.
REQ-026 Reset assertion mid-QUALIFY or mid-TRIGGERED SHALL abandon the event without incrementing event_count.
REQ-027 After reset release, the first state change SHALL occur no earlier than the first rising clk edge with arm=1.

Structure
REQ-028 The state enum, its 3-bit encoding and the default DEBOUNCE/HOLDOFF constants SHALL reside in shared package alarm_pkg.
REQ-029 The synchronizer SHALL be a separate sub-module alarm_sync (two flops, async active-low reset to 0); all else is in alarm_sensor_filter.
REQ-030 qcnt and hcnt SHALL each be 8 bits.

Verification (bench parameters DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-031 arm=1, raw_in high from E1 held -> trig=1 after E6, event_count=1; trig stays high with no ack.
REQ-032 arm=1, raw_in high for 3 cycles, low, high 3 cycles -> trig never asserts, event_count=0.
REQ-033 Trigger, ack one cycle, raw_in low -> trig=0 next edge, armed=1; new raw_in pulse of 4+ cycles qualifies only after 8 holdoff cycles elapse.
REQ-034 Trigger, ack with raw_in still high -> FSM stays HOLDOFF, trig=0, until raw_in low, then ARMED.
REQ-035 During QUALIFY or TRIGGERED drop arm -> DISARMED, trig=0, armed=0 next edge; assert reset mid-QUALIFY -> all outputs 0 immediately, event_count unchanged at 0.
REQ-036 260 trigger/ack cycles -> event_count=255 and holds.
